// File: rtl/precision_tran_pipe_if.sv
// Operand-side and MAC-side handshake bundle for the precision converter.
interface precision_tran_pipe_if #(
  parameter int LANES = 4,
  parameter int W_IN  = 16,
  parameter int W_OUT = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   round_mode;
  logic [LANES*W_IN-1:0]  float_vec_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*W_OUT-1:0] float_vec_out;
  logic [LANES*4-1:0]     lane_flags;

  modport master (
    output in_valid, round_mode, float_vec_in, out_ready,
    input  in_ready, out_valid, float_vec_out, lane_flags
  );

  modport slave (
    input  in_valid, round_mode, float_vec_in, out_ready,
    output in_ready, out_valid, float_vec_out, lane_flags
  );
endinterface

// File: rtl/precision_tran_pipe.sv
// Multi-lane float format converter with RNE/RTZ rounding; 2-cycle latency, 1 beat/cycle.
// Valid/ready stall pipeline, in_ready follows out_ready combinationally; PRECISION_TRAN_STICKY_FLAGS_EN adds sticky status.
module precision_tran_pipe #(
  parameter int EXP_WIDTH_IN   = 5,
  parameter int FRAC_WIDTH_IN  = 10,
  parameter int EXP_WIDTH_OUT  = 4,
  parameter int FRAC_WIDTH_OUT = 3,
  parameter int LANES          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef PRECISION_TRAN_STICKY_FLAGS_EN
  input  logic       status_clr,
  output logic [3:0] status_sticky,
`endif
  precision_tran_pipe_if.slave bus
);
  localparam int EI       = EXP_WIDTH_IN;
  localparam int FI       = FRAC_WIDTH_IN;
  localparam int EO       = EXP_WIDTH_OUT;
  localparam int FO       = FRAC_WIDTH_OUT;
  localparam int W_IN     = 1 + EI + FI;
  localparam int W_OUT    = 1 + EO + FO;
  localparam int EW       = ((EI > EO) ? EI : EO) + 2;
  localparam int BIAS_IN  = (1 << (EI - 1)) - 1;
  localparam int BIAS_OUT = (1 << (EO - 1)) - 1;

  localparam logic signed [EW-1:0] BIAS_ADJ = EW'(BIAS_OUT - BIAS_IN);
  localparam logic signed [EW-1:0] E_MAX    = EW'((1 << EO) - 1);
  localparam logic signed [EW-1:0] E_ZERO   = '0;
  localparam logic [EO-1:0]        EXP_MAXF = EO'((1 << EO) - 2);

  typedef enum logic [2:0] {K_NORM, K_ZERO, K_INF, K_NAN, K_FLUSH} kind_e;

  typedef struct packed {
    logic                 sign;
    kind_e                kind;
    logic signed [EW-1:0] e;
    logic [FO-1:0]        kept;
    logic                 grd;
    logic                 stk;
  } s1_lane_t;

  s1_lane_t [LANES-1:0]   s1_d, s1_q;
  logic                   s1_rm_q, s1_vld_q, s2_vld_q;
  logic [LANES*W_OUT-1:0] res_d, res_q;
  logic [LANES*4-1:0]     flg_d, flg_q;
  logic                   s1_adv, s2_adv;

  // Extending the fraction by FO+2 zeros lets one slicing rule cover both narrowing and widening.
  function automatic s1_lane_t classify(input logic [W_IN-1:0] x);
    logic [EI-1:0]      ex;
    logic [FI-1:0]      fr;
    logic [FI+FO+1:0]   ext;
    s1_lane_t           r;
    ex     = x[W_IN-2 -: EI];
    fr     = x[FI-1:0];
    ext    = {fr, {(FO+2){1'b0}}};
    r.sign = x[W_IN-1];
    r.e    = $signed({{(EW-EI){1'b0}}, ex}) + BIAS_ADJ;
    r.kept = ext[FI+FO+1 -: FO];
    r.grd  = ext[FI+1];
    r.stk  = |ext[FI:0];
    if (ex == '1)          r.kind = (fr != '0) ? K_NAN : K_INF;
    else if (ex == '0)     r.kind = (fr != '0) ? K_FLUSH : K_ZERO;
    else if (r.e <= E_ZERO) r.kind = K_FLUSH;
    else                   r.kind = K_NORM;
    return r;
  endfunction

  // Returns {flags[3:0], packed result}; flags are {inexact, underflow, overflow, invalid}.
  function automatic logic [W_OUT+3:0] round_lane(input s1_lane_t a, input logic rtz);
    logic [FO:0]          m;
    logic signed [EW-1:0] e;
    logic                 inc;
    logic [W_OUT-1:0]     res;
    logic [3:0]           f;
    inc = !rtz && a.grd && (a.stk || a.kept[0]);
    m   = {1'b0, a.kept} + {{FO{1'b0}}, inc};
    e   = a.e + EW'(m[FO]);
    res = {a.sign, {(W_OUT-1){1'b0}}};
    f   = 4'b0000;
    case (a.kind)
      K_NAN: begin
        res          = {a.sign, {EO{1'b1}}, {FO{1'b0}}};
        res[FO-1]    = 1'b1;
        f            = 4'b0001;
      end
      K_INF:   res = {a.sign, {EO{1'b1}}, {FO{1'b0}}};
      K_ZERO:  f   = 4'b0000;
      K_FLUSH: f   = 4'b1100;
      default: begin
        if (e >= E_MAX) begin
          f   = 4'b1010;
          res = rtz ? {a.sign, EXP_MAXF, {FO{1'b1}}} : {a.sign, {EO{1'b1}}, {FO{1'b0}}};
        end else begin
          res = {a.sign, e[EO-1:0], m[FO-1:0]};
          f   = {a.grd || a.stk, 3'b000};
        end
      end
    endcase
    return {f, res};
  endfunction

  always_comb begin
    s1_d  = '0;
    res_d = '0;
    flg_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_d[i] = classify(bus.float_vec_in[i*W_IN +: W_IN]);
      {flg_d[4*i +: 4], res_d[i*W_OUT +: W_OUT]} = round_lane(s1_q[i], s1_rm_q);
    end
  end

  assign s2_adv = !s2_vld_q || bus.out_ready;
  assign s1_adv = !s1_vld_q || s2_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_rm_q  <= 1'b0;
      s1_q     <= '0;
      s2_vld_q <= 1'b0;
      res_q    <= '0;
      flg_q    <= '0;
    end else begin
      if (s1_adv) begin
        s1_vld_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_q    <= s1_d;
          s1_rm_q <= bus.round_mode;
        end
      end
      if (s2_adv) begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          res_q <= res_d;
          flg_q <= flg_d;
        end
      end
    end
  end

  assign bus.in_ready      = s1_adv;
  assign bus.out_valid     = s2_vld_q;
  assign bus.float_vec_out = res_q;
  assign bus.lane_flags    = flg_q;

`ifdef PRECISION_TRAN_STICKY_FLAGS_EN
  logic [3:0] sticky_d, sticky_q, beat_or;

  // A set in the same cycle as a clear wins, so the clear is applied first.
  always_comb begin
    beat_or = '0;
    for (int i = 0; i < LANES; i++) beat_or = beat_or | flg_q[4*i +: 4];
    sticky_d = status_clr ? 4'b0000 : sticky_q;
    if (s2_vld_q && bus.out_ready) sticky_d = sticky_d | beat_or;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign status_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_precision_tran_pipe.sv
// Directed checks of the fp16 -> E4M3 converter: rounding, exceptions, latency, stalls, reset.
module tb_precision_tran_pipe;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  precision_tran_pipe_if #(.LANES(4), .W_IN(16), .W_OUT(8)) bus ();

`ifdef PRECISION_TRAN_STICKY_FLAGS_EN
  logic       status_clr;
  logic [3:0] status_sticky;
  precision_tran_pipe dut (.clk(clk), .rst_n(rst_n), .status_clr(status_clr),
                           .status_sticky(status_sticky), .bus(bus));
`else
  precision_tran_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam int NB = 5;
  logic [63:0] vin [NB];
  logic        rmv [NB];
  logic [31:0] eo  [NB];
  logic [15:0] ef  [NB];
  logic [15:0] rpat;

  initial begin
    logic        held;
    logic [31:0] hv;
    logic [15:0] hf;
    int          sent;
    int          got;

    vin[0] = 64'h7BFF_3CC0_3C40_3C00; rmv[0] = 1'b1; eo[0] = 32'h77393838; ef[0] = 16'hA880;
    vin[1] = 64'hFC00_7E00_8001_1400; rmv[1] = 1'b0; eo[1] = 32'hF87C8000; ef[1] = 16'h01CC;
    vin[2] = 64'h7C00_8000_0000_C000; rmv[2] = 1'b0; eo[2] = 32'h788000C0; ef[2] = 16'h0000;
    vin[3] = 64'h3FFF_5B80_2000_2400; rmv[3] = 1'b0; eo[3] = 32'h40770008; ef[3] = 16'h80C0;
    vin[4] = 64'h3FFF_5B80_2000_2400; rmv[4] = 1'b1; eo[4] = 32'h3F770008; ef[4] = 16'h80C0;
    rpat   = 16'b1011_0011_0101_1100;

    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.round_mode   = 1'b0;
    bus.float_vec_in = '0;
    bus.out_ready    = 1'b1;
`ifdef PRECISION_TRAN_STICKY_FLAGS_EN
    status_clr = 1'b0;
`endif
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_vec_out", bus.float_vec_out, 0);
    chk("rst_flags", bus.lane_flags, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);

    // RNE beat: 1.0, tie-to-even, round-up, overflow to Inf
    bus.in_valid     = 1'b1;
    bus.float_vec_in = 64'h7BFF_3CC0_3C40_3C00;
    bus.round_mode   = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk("lat1_out_valid", bus.out_valid, 0);
    tick();
    chk("lat2_out_valid", bus.out_valid, 1);
    chk("rne_vec", bus.float_vec_out, 32'h783A3838);
    chk("rne_flags", bus.lane_flags, 16'hA880);
    tick();
    chk("drain_out_valid", bus.out_valid, 0);

    // Back-to-back stream under a fixed irregular out_ready pattern
    held = 1'b0; hv = '0; hf = '0; sent = 0; got = 0;
    for (int cyc = 0; cyc < 200 && got < NB; cyc++) begin
      if (held) begin
        chk("hold_vld", bus.out_valid, 1);
        chk("hold_vec", bus.float_vec_out, hv);
        chk("hold_flg", bus.lane_flags, hf);
      end
      bus.out_ready = rpat[cyc % 16];
      if (sent < NB) begin
        bus.in_valid     = 1'b1;
        bus.float_vec_in = vin[sent];
        bus.round_mode   = rmv[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      held = bus.out_valid && !bus.out_ready;
      hv   = bus.float_vec_out;
      hf   = bus.lane_flags;
      if (bus.out_valid && bus.out_ready) begin
        chk("stream_vec", bus.float_vec_out, eo[got]);
        chk("stream_flg", bus.lane_flags, ef[got]);
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    chk("stream_count", got, NB);
    bus.in_valid = 1'b0;
    tick();
    chk("stream_empty", bus.out_valid, 0);

    // Stall with out_ready low: two beats fill the pipe, then in_ready drops
    bus.out_ready    = 1'b0;
    bus.in_valid     = 1'b1;
    bus.float_vec_in = vin[2];
    bus.round_mode   = 1'b0;
    #1;
    chk("stall_rdy0", bus.in_ready, 1);
    tick();
    bus.float_vec_in = vin[1];
    #1;
    chk("stall_rdy1", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("stall_full_rdy", bus.in_ready, 0);
    chk("stall_full_vld", bus.out_valid, 1);
    chk("stall_full_vec", bus.float_vec_out, eo[2]);
    tick();
    chk("stall_hold_rdy", bus.in_ready, 0);
    chk("stall_hold_vec", bus.float_vec_out, eo[2]);
    bus.out_ready = 1'b1;
    #1;
    chk("stall_release_rdy", bus.in_ready, 1);
    tick();
    chk("stall_second_vld", bus.out_valid, 1);
    chk("stall_second_vec", bus.float_vec_out, eo[1]);
    chk("stall_second_flg", bus.lane_flags, ef[1]);
    tick();
    chk("stall_empty", bus.out_valid, 0);

`ifdef PRECISION_TRAN_STICKY_FLAGS_EN
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    chk("sticky_clr0", status_sticky, 4'b0000);
    bus.in_valid     = 1'b1;
    bus.float_vec_in = 64'h0000_0000_0000_7BFF;
    bus.round_mode   = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("sticky_beat_vec", bus.float_vec_out, 32'h00000078);
    tick();
    chk("sticky_set", status_sticky, 4'b1010);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    chk("sticky_clr1", status_sticky, 4'b0000);
`endif

    // Reset while a beat is held at the output
    bus.out_ready    = 1'b0;
    bus.in_valid     = 1'b1;
    bus.float_vec_in = vin[3];
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("mid_pre_vld", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", bus.out_valid, 0);
    chk("mid_rst_vec", bus.float_vec_out, 0);
    tick();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("mid_post_vld", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
